// File: rtl/seg_share_arbiter.sv
// Round-robin sharing of one signed 4-bit seven-segment digit among N_REQ requesters.
// Each accepted value is latched and shown for DWELL cycles before the next arbitration.
module seg_share_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DWELL = 8,
  parameter int unsigned IDX_W = 2,
  parameter int unsigned CNT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [4*N_REQ-1:0] val,
  output logic [N_REQ-1:0]   grant,
  output logic [3:0]         a_out,
  output logic               disp_valid,
  output logic [IDX_W-1:0]   owner,
  output logic               neg
);

  localparam int unsigned SelW = $clog2(N_REQ);

  typedef enum logic {StIdle, StShow} state_e;

  state_e            r_state, w_state_d;
  logic [SelW-1:0]   r_last, w_last_d;
  logic [CNT_W-1:0]  r_cnt, w_cnt_d;
  logic [3:0]        r_a, w_a_d;
  logic [IDX_W-1:0]  r_owner, w_owner_d;
  logic [N_REQ-1:0]  r_grant, w_grant_d;
  logic              r_valid, w_valid_d;

  logic [3:0]        w_vals [N_REQ];
  logic              w_found;
  logic [SelW-1:0]   w_win;
  logic [SelW-1:0]   w_sel;
  logic              w_accept;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign w_vals[g] = val[4*g+3 -: 4];
  end

  // First set request strictly after the last winner, wrapping modulo N_REQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sel   = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      w_sel = SelW'((32'(r_last) + i) % N_REQ);
      if (!w_found && req[w_sel]) begin
        w_found = 1'b1;
        w_win   = w_sel;
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_last_d  = r_last;
    w_cnt_d   = r_cnt;
    w_a_d     = r_a;
    w_owner_d = r_owner;
    w_grant_d = '0;
    w_valid_d = r_valid;
    w_accept  = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (w_found) w_accept = 1'b1;
      end
      StShow: begin
        if (r_cnt == '0) begin
          if (w_found) begin
            w_accept = 1'b1;
          end else begin
            w_state_d = StIdle;
            w_valid_d = 1'b0;
          end
        end else begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end
      default: ;
    endcase

    if (w_accept) begin
      w_state_d = StShow;
      w_last_d  = w_win;
      w_owner_d = IDX_W'(w_win);
      w_a_d     = w_vals[w_win];
      w_grant_d = N_REQ'(1) << w_win;
      w_valid_d = 1'b1;
      w_cnt_d   = CNT_W'(DWELL - 1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_last  <= SelW'(N_REQ - 1);
      r_cnt   <= '0;
      r_a     <= '0;
      r_owner <= '0;
      r_grant <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_last  <= w_last_d;
      r_cnt   <= w_cnt_d;
      r_a     <= w_a_d;
      r_owner <= w_owner_d;
      r_grant <= w_grant_d;
      r_valid <= w_valid_d;
    end
  end

  assign grant      = r_grant;
  assign a_out      = r_a;
  assign disp_valid = r_valid;
  assign owner      = r_owner;
  assign neg        = r_a[3] & r_valid;

endmodule

// File: tb/tb_seg_share_arbiter.sv
// Directed bench for seg_share_arbiter with N_REQ=4, DWELL=8; expectations hand-computed.
module tb_seg_share_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] val;
  logic [3:0]  grant;
  logic [3:0]  a_out;
  logic        disp_valid;
  logic [1:0]  owner;
  logic        neg;

  int n_cmp = 0;
  int n_err = 0;

  seg_share_arbiter #(
    .N_REQ(4),
    .DWELL(8),
    .IDX_W(2),
    .CNT_W(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .val        (val),
    .grant      (grant),
    .a_out      (a_out),
    .disp_valid (disp_valid),
    .owner      (owner),
    .neg        (neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic [3:0] a,
                         input logic [1:0] o, input logic v, input logic n);
    chk({tag, ".grant"}, 16'(grant), 16'(g));
    chk({tag, ".a_out"}, 16'(a_out), 16'(a));
    chk({tag, ".owner"}, 16'(owner), 16'(o));
    chk({tag, ".valid"}, 16'(disp_valid), 16'(v));
    chk({tag, ".neg"}, 16'(neg), 16'(n));
  endtask

  // Slot already accepted one edge ago: check the remaining DWELL-1 cycles hold steady.
  task automatic hold_slot(input string tag, input logic [3:0] a, input logic [1:0] o,
                           input logic n);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk_all(tag, 4'b0000, a, o, 1'b1, n);
    end
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    val   = '0;
    #12;
    chk_all("reset", 4'b0000, 4'h0, 2'd0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;

    // Single request, full dwell then idle with a_out held.
    req = 4'b0001;
    val = 16'h0003;
    tick();
    chk_all("t1.accept", 4'b0001, 4'h3, 2'd0, 1'b1, 1'b0);
    req = 4'b0000;
    hold_slot("t1.hold", 4'h3, 2'd0, 1'b0);
    tick();
    chk_all("t1.end", 4'b0000, 4'h3, 2'd0, 1'b0, 1'b0);
    tick();
    chk_all("t1.idle", 4'b0000, 4'h3, 2'd0, 1'b0, 1'b0);

    // Fairness: all requesting, pointer fresh from reset.
    reset = 1'b1;
    #2;
    reset = 1'b0;
    req = 4'b1111;
    val = 16'h78F2;
    tick();
    chk_all("t2.s0", 4'b0001, 4'h2, 2'd0, 1'b1, 1'b0);
    hold_slot("t2.h0", 4'h2, 2'd0, 1'b0);
    tick();
    chk_all("t2.s1", 4'b0010, 4'hF, 2'd1, 1'b1, 1'b1);
    hold_slot("t2.h1", 4'hF, 2'd1, 1'b1);
    tick();
    chk_all("t2.s2", 4'b0100, 4'h8, 2'd2, 1'b1, 1'b1);
    hold_slot("t2.h2", 4'h8, 2'd2, 1'b1);
    tick();
    chk_all("t2.s3", 4'b1000, 4'h7, 2'd3, 1'b1, 1'b0);
    hold_slot("t2.h3", 4'h7, 2'd3, 1'b0);
    tick();
    chk_all("t2.s4", 4'b0001, 4'h2, 2'd0, 1'b1, 1'b0);

    // Requester 1 keeps holding while 3 also waits: 1, then 3, then 1 again.
    req = 4'b1010;
    hold_slot("t3.h0", 4'h2, 2'd0, 1'b0);
    tick();
    chk_all("t3.s1", 4'b0010, 4'hF, 2'd1, 1'b1, 1'b1);
    hold_slot("t3.h1", 4'hF, 2'd1, 1'b1);
    tick();
    chk_all("t3.s3", 4'b1000, 4'h7, 2'd3, 1'b1, 1'b0);
    hold_slot("t3.h3", 4'h7, 2'd3, 1'b0);
    tick();
    chk_all("t3.s1b", 4'b0010, 4'hF, 2'd1, 1'b1, 1'b1);
    req = 4'b0000;
    hold_slot("t3.h1b", 4'hF, 2'd1, 1'b1);
    tick();
    chk_all("t3.end", 4'b0000, 4'hF, 2'd1, 1'b0, 1'b0);

    // Value captured only at acceptance.
    req = 4'b0100;
    val = 16'h0500;
    tick();
    chk_all("t4.accept", 4'b0100, 4'h5, 2'd2, 1'b1, 1'b0);
    req = 4'b0000;
    run(3);
    val = 16'h0900;
    tick();
    chk_all("t4.mid", 4'b0000, 4'h5, 2'd2, 1'b1, 1'b0);
    run(3);
    chk_all("t4.last", 4'b0000, 4'h5, 2'd2, 1'b1, 1'b0);
    tick();
    chk_all("t4.end", 4'b0000, 4'h5, 2'd2, 1'b0, 1'b0);

    // Reset mid-slot; afterwards pointer restarts so requester 1 wins (not 2).
    req = 4'b0110;
    val = 16'h00B0;
    tick();
    chk_all("t5.accept", 4'b0010, 4'hB, 2'd1, 1'b1, 1'b1);
    run(3);
    reset = 1'b1;
    #1;
    chk_all("t5.inrst", 4'b0000, 4'h0, 2'd0, 1'b0, 1'b0);
    run(2);
    chk_all("t5.held", 4'b0000, 4'h0, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    chk_all("t5.after", 4'b0010, 4'hB, 2'd1, 1'b1, 1'b1);
    req = 4'b0000;
    hold_slot("t5.hold", 4'hB, 2'd1, 1'b1);
    tick();
    chk_all("t5.end", 4'b0000, 4'hB, 2'd1, 1'b0, 1'b0);

    // Short req0 pulse during requester 2's slot is dropped, not queued.
    req = 4'b0100;
    val = 16'h0600;
    tick();
    chk_all("t6.accept", 4'b0100, 4'h6, 2'd2, 1'b1, 1'b0);
    req = 4'b0000;
    run(2);
    req = 4'b0001;
    tick();
    req = 4'b0000;
    chk_all("t6.pulse", 4'b0000, 4'h6, 2'd2, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_all("t6.rest", 4'b0000, 4'h6, 2'd2, 1'b1, 1'b0);
    end
    tick();
    chk_all("t6.end", 4'b0000, 4'h6, 2'd2, 1'b0, 1'b0);
    tick();
    chk_all("t6.idle", 4'b0000, 4'h6, 2'd2, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
